// File: rtl/laplace_stream.sv
// Streaming 4-neighbour Laplacian: two line buffers feed a cross window, then a
// two-register arithmetic pipeline produces the clamped b+d+f+h-4e for interior pixels.
module laplace_stream #(
   parameter int PIX_W       = 8,
   parameter int IMG_W       = 640,
   parameter int IMG_H       = 480,
   parameter int APPROX_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   output logic             out_sof,
   output logic             out_eof,
   output logic [PIX_W-1:0] out_pixel
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int K  = APPROX_BITS;
   localparam int HW = PIX_W - K;
   localparam int TW = PIX_W + 4;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic             started_q, started_d;
   logic             mode_q, mode_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [PIX_W-1:0] lb1_q [IMG_W];
   logic [PIX_W-1:0] lb2_q [IMG_W];
   logic [PIX_W-1:0] top_q, mid1_q, mid2_q, bot_q;
   logic [PIX_W:0]   p1_q, p2_q;
   logic [PIX_W-1:0] e_q;
   logic             v1_q, sof1_q, eof1_q;
   logic             out_valid_q, out_sof_q, out_eof_q;
   logic [PIX_W-1:0] out_pixel_q;

   logic             accept, interior, cur_mode;
   logic [CW-1:0]    cur_col;
   logic [RW-1:0]    cur_row;
   logic [PIX_W-1:0] rd1, rd2, clamped;
   logic signed [TW-1:0] total;

   // Exact or lower-part-OR pair adder; the OR part forwards its top-bit AND as carry.
   function automatic logic [PIX_W:0] pair_add(input logic [PIX_W-1:0] x,
                                               input logic [PIX_W-1:0] y,
                                               input logic             approx);
      logic [HW:0]    hi;
      logic [PIX_W:0] sum;
      hi = {1'b0, x[PIX_W-1:K]} + {1'b0, y[PIX_W-1:K]} + {{HW{1'b0}}, x[K-1] & y[K-1]};
      if (approx) sum = {hi, x[K-1:0] | y[K-1:0]};
      else        sum = {1'b0, x} + {1'b0, y};
      return sum;
   endfunction

   always_comb begin
      accept    = in_valid & (in_sof | started_q);
      cur_col   = in_sof ? '0 : col_q;
      cur_row   = in_sof ? '0 : row_q;
      cur_mode  = in_sof ? mode : mode_q;
      rd1       = lb1_q[cur_col];
      rd2       = lb2_q[cur_col];
      started_d = started_q | (in_valid & in_sof);
      mode_d    = accept ? cur_mode : mode_q;
      col_d     = col_q;
      row_d     = row_q;
      if (accept) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
      end
      interior = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         started_q <= 1'b0;
         mode_q    <= 1'b0;
         col_q     <= '0;
         row_q     <= '0;
         v1_q      <= 1'b0;
         sof1_q    <= 1'b0;
         eof1_q    <= 1'b0;
      end else begin
         started_q <= started_d;
         mode_q    <= mode_d;
         col_q     <= col_d;
         row_q     <= row_d;
         v1_q      <= interior;
         sof1_q    <= interior && (cur_row == RW'(2)) && (cur_col == CW'(2));
         eof1_q    <= interior && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      end
   end

   // NOTE: line buffers and datapath registers carry no reset; the valid chain alone
   // decides whether their contents ever reach the output.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[cur_col] <= in_pixel;
         lb2_q[cur_col] <= rd1;
         top_q          <= rd2;
         mid2_q         <= mid1_q;
         mid1_q         <= rd1;
         bot_q          <= in_pixel;
      end
      // Window taps: b=top_q, d=mid2_q, e=mid1_q, f=rd1 (column c), h=bot_q.
      p1_q <= pair_add(top_q, mid2_q, cur_mode);
      p2_q <= pair_add(rd1, bot_q, cur_mode);
      e_q  <= mid1_q;
   end

   always_comb begin
      total = $signed({3'b000, p1_q}) + $signed({3'b000, p2_q}) - $signed({2'b00, e_q, 2'b00});
      if (total[TW-1])               clamped = '0;
      else if (|total[TW-2:PIX_W])   clamped = '1;
      else                           clamped = total[PIX_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         out_valid_q <= v1_q;
         out_sof_q   <= v1_q & sof1_q;
         out_eof_q   <= v1_q & eof1_q;
         out_pixel_q <= clamped;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_laplace_stream.sv
// Scoreboard bench for laplace_stream on a 5x5 frame: expectations are computed from
// the driven image when each window-completing pixel is sent and matched on output.
module tb_laplace_stream;

   localparam int PW = 8;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int K  = 2;

   logic          clk = 1'b0;
   logic          rst, mode, in_valid, in_sof;
   logic [PW-1:0] in_pixel;
   logic          out_valid, out_sof, out_eof;
   logic [PW-1:0] out_pixel;

   laplace_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .APPROX_BITS(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .out_pixel (out_pixel)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int pix;
      bit sof;
      bit eof;
      int due;
   } exp_t;

   exp_t  sb[$];
   exp_t  got_e;
   int    img [H][W];
   int    n_checks = 0;
   int    n_pass   = 0;
   string scen     = "reset";

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic int padd(input int x, input int y, input bit ap);
      int lo, hi;
      if (!ap) return x + y;
      lo = (x | y) & ((1 << K) - 1);
      hi = (x >> K) + (y >> K) + ((x >> (K - 1)) & (y >> (K - 1)) & 1);
      return (hi << K) | lo;
   endfunction

   // Laplacian centred on (r,c) of the current image.
   function automatic int lap(input int r, input int c, input bit ap);
      int t;
      t = padd(img[r-1][c], img[r][c-1], ap) + padd(img[r][c+1], img[r+1][c], ap) - 4 * img[r][c];
      if (t < 0)   return 0;
      if (t > 255) return 255;
      return t;
   endfunction

   task automatic fill(input int v, input int centre);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = v;
      img[2][2] = centre;
   endtask

   task automatic fill_random();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = PW'($urandom);
      mode     = 1'($urandom);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit md, input bit throttle, input int npix);
      exp_t x;
      int   r, c;
      for (int i = 0; i < npix; i++) begin
         r        = i / W;
         c        = i % W;
         in_valid = 1'b1;
         in_sof   = (i == 0);
         in_pixel = PW'(img[r][c]);
         mode     = (i == 0) ? md : 1'($urandom);
         if (r >= 2 && c >= 2) begin
            x.pix = lap(r - 1, c - 1, md);
            x.sof = (r == 2 && c == 2);
            x.eof = (r == H - 1 && c == W - 1);
            x.due = cyc + 2;
            sb.push_back(x);
         end
         @(posedge clk);
         #1;
         if (throttle) idle(2);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check({scen, ":drained"}, sb.size(), 0);
      idle(3);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ":out_valid"}, out_valid, 0);
      check({tag, ":out_sof"},   out_sof,   0);
      check({tag, ":out_eof"},   out_eof,   0);
      check({tag, ":out_pixel"}, out_pixel, 0);
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            check({scen, ":spurious_out_valid"}, 1, 0);
         end else begin
            got_e = sb.pop_front();
            check({scen, ":pixel"},   out_pixel, got_e.pix);
            check({scen, ":sof"},     out_sof,   got_e.sof);
            check({scen, ":eof"},     out_eof,   got_e.eof);
            check({scen, ":latency"}, cyc,       got_e.due);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = '0;
      mode     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      rst = 1'b0;
      idle(2);

      scen = "const";        fill(100, 100); send_frame(0, 0, 25); wait_drain();
      scen = "impulse";      fill(0, 255);   send_frame(0, 0, 25); wait_drain();
      scen = "approx_exact"; fill(3, 0);     send_frame(0, 0, 25); wait_drain();
      scen = "approx_on";    fill(3, 0);     send_frame(1, 0, 25); wait_drain();
      scen = "sat_exact";    fill(200, 10);  send_frame(0, 0, 25); wait_drain();
      scen = "sat_approx";   fill(200, 10);  send_frame(1, 0, 25); wait_drain();

      scen = "random_b2b";
      fill_random();
      send_frame(1, 0, 25);
      send_frame(0, 0, 25);
      wait_drain();

      scen = "throttled";    fill(0, 255);   send_frame(0, 1, 25); wait_drain();

      // Reset lands while the (3,2) result is still in flight.
      scen = "reset_mid";
      fill(0, 255);
      send_frame(0, 0, 18);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      check_quiet("reset_mid");
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         in_sof   = 1'b0;
         in_pixel = PW'($urandom);
         @(posedge clk);
         #1;
      end
      idle(3);
      check("reset_mid:gated_out_valid", out_valid, 0);
      send_frame(0, 0, 25);
      wait_drain();

      // Frame restarted at pixel (1,4) with a different mode.
      scen = "sof_restart";
      fill_random();
      send_frame(0, 0, 9);
      fill(3, 0);
      send_frame(1, 0, 25);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/laplace_stream.md
# laplace_stream

Streaming 4-neighbour Laplacian filter, the pipelined and parametrised successor of the combinational 5-input Laplacian block. It accepts one raster-scan pixel per valid cycle and buffers two image lines internally. It forms the 3x3 cross window (b up, d left, e centre, f right, h down) and emits the clamped result s = b+d+f+h-4e for every interior pixel. The pair sums b+d and f+h are computed exactly or with a lower-part-OR approximate adder, selected per frame.

## Interface
- PIX_W, 8: pixel width in bits, for input and output.
- IMG_W, 640: pixels per line, at least 3.
- IMG_H, 480: lines per frame, at least 3.
- APPROX_BITS, 2: LSBs handled by OR in approximate mode, 1..PIX_W-1.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = exact pair adders, 1 = approximate; sampled with the in_sof pixel.
- in_valid  in  1  in_pixel is accepted this cycle; no backpressure.
- in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a frame.
- in_pixel  in  PIX_W  input pixel.
- out_valid  out  1  out_pixel valid this cycle.
- out_sof  out  1  with out_valid; marks the first interior output (1,1).
- out_eof  out  1  with out_valid; marks the last interior output (IMG_H-2, IMG_W-2).
- out_pixel  out  PIX_W  clamped Laplacian.

## Operation
- **Position tracking.** Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on in_valid.
  - col wraps to 0 and row increments at the end of a line.
  - After the last pixel of the frame, both return to 0 and the block waits for the next frame.
- **Frame start.** An accepted pixel with in_sof=1 forces the counters to (0,0) for that pixel. This applies even mid-frame, which restarts the frame.
  - Line-buffer contents need not be cleared: no output is produced until rows 0..1 of the new frame have been refilled.
- **Frame gating.** Pixels accepted before the first in_sof after reset are ignored: they produce no output and do not advance the counters.
- **Line buffers.** Two buffers of IMG_W x PIX_W hold rows r-1 and r-2. Each is read and written at address col in the same valid cycle.
- **Window registers.** A 3-column shift window of rows r-2, r-1 and r. When pixel (r,c) is accepted, the window is centred on (r-1, c-1):
  - b = (r-2, c-1)
  - d = (r-1, c-2)
  - e = (r-1, c-1)
  - f = (r-1, c)
  - h = (r, c-1)
- **Output rule.** An output is produced only when r ≥ 2 and c ≥ 2. That gives exactly (IMG_H-2)(IMG_W-2) outputs per frame. Border pixels produce no output.
- **Arithmetic.**
  - Pair sums p1 = b+d and p2 = f+h are PIX_W+1 bits.
  - Total = p1 + p2 - 4e, evaluated signed at PIX_W+4 bits.
  - s = 0 if total < 0; s = 2^PIX_W-1 if total > 2^PIX_W-1; otherwise s = total.
- **Approximate pair adder** (mode=1), with k = APPROX_BITS and inputs x, y:
  - sum[k-1:0] = x[k-1:0] | y[k-1:0].
  - sum[PIX_W:k] = x[PIX_W-1:k] + y[PIX_W-1:k] + (x[k-1] & y[k-1]).
  - Both p1 and p2 use this adder. The final 3-operand combine and the 4e term are always exact.
- **Mode latching.** mode is latched on the accepted in_sof pixel and held for the whole frame. Changes on mode at other times are ignored.

## Timing
- **Pipeline.** Stage 0 covers the line-buffer read and window shift, stage 1 the pair sums, stage 2 the combine, clamp and output register.
- **Latency.** A window-completing pixel accepted in cycle t gives out_valid=1 in cycle t+2.
  - Outputs keep input order.
  - Gaps in in_valid propagate unchanged: the pipeline advances every cycle, and the valid bit travels with the data.
- **out_sof / out_eof.** Asserted in the same cycle as out_valid for outputs (1,1) and (IMG_H-2, IMG_W-2) respectively.
- **Reset (rst=1 at a clock edge).**
  - out_valid, out_sof, out_eof and out_pixel become 0.
  - Counters become (0,0), the pipeline valid bits are cleared and the latched mode becomes 0.
  - Line-buffer contents are don't-care.
  - Reset mid-frame discards all in-flight results: no out_valid in the cycles after reset is released.
- **Throughput.** One pixel per cycle sustained, with no stall cycles at line or frame boundaries.

## Test plan
- **Constant frame:** IMG_W=IMG_H=5, all pixels 100, mode=0 -> 9 outputs, all 0, out_sof on the 1st and out_eof on the 9th, each 2 cycles after its completing input.
- **Impulse:** 5x5 frame of zeros except (2,2)=255, mode=0 -> output (2,2)=0 (clamped from -1020); (1,2), (2,1), (2,3) and (3,2) = 255; the other 4 outputs = 0.
- **Approximate mode:** window b=d=f=h=3, e=0, APPROX_BITS=2 -> exact mode gives 12, mode=1 gives 14 (each pair gives 7); window b=d=f=h=200, e=10 -> 255 (clamped) in both modes.
- **Throttled input:** the impulse frame with in_valid toggling 1,0,0,1… -> same 9 values in the same order, each exactly 2 cycles after its completing input.
- **Reset mid-frame:** rst for 1 cycle during row 3 -> out_valid low in the following cycles; the next in_sof frame produces the full correct 9 outputs.
- **Mid-frame in_sof:** in_sof asserted at pixel (1,4) of a 5x5 frame -> counting restarts; no output until pixel (2,2) of the new frame; mode is re-latched.
